// File: rtl/nonce_batch_scanner.sv
// Nonce batch scanner: launches N_LANES hash lanes per batch, captures their results, and
// scans them against a target. It reports the first hit, the hit count and the end status.
module nonce_batch_scanner #(
  parameter int unsigned N_LANES = 10,
  parameter int unsigned HASH_W  = 256,
  parameter int unsigned NONCE_W = 32,
  parameter int unsigned STAGGER = 1,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic                        stop_on_first_i,
  input  logic [HASH_W-1:0]           target_i,
  input  logic [NONCE_W-1:0]          nonce_first_i,
  input  logic [NONCE_W-1:0]          nonce_last_i,
  output logic [N_LANES-1:0]          lane_begin_o,
  input  logic [N_LANES-1:0]          lane_done_i,
  input  logic [N_LANES*HASH_W-1:0]   lane_hash_i,
  output logic [NONCE_W-1:0]          batch_nonce_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        found_o,
  output logic [NONCE_W-1:0]          found_nonce_o,
  output logic [15:0]                 found_count_o,
  output logic                        exhausted_o,
  output logic                        timeout_err_o
);

  localparam int unsigned IdxW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam int unsigned NW1  = NONCE_W + 1;
  localparam logic [IdxW-1:0]    LastIdx     = IdxW'(N_LANES - 1);
  localparam logic [CntW-1:0]    TimeoutLast = CntW'(TIMEOUT - 1);
  localparam logic [NONCE_W:0]   NLanesW     = NW1'(N_LANES);
  localparam logic [N_LANES-1:0] LaneZeroBit = N_LANES'(1);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StScan, StNext, StFinish} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [N_LANES-1:0]   mask_q, mask_d;
  logic [HASH_W-1:0]    hash_buf_q [N_LANES];
  logic [NONCE_W-1:0]   batch_q, batch_d;
  logic [NONCE_W-1:0]   last_q, last_d;
  logic [HASH_W-1:0]    target_q, target_d;
  logic                 stop_q, stop_d;
  logic                 found_q, found_d;
  logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
  logic [15:0]          found_count_q, found_count_d;
  logic                 exhausted_q, exhausted_d;
  logic                 timeout_q, timeout_d;

  logic                 accept;
  logic [N_LANES-1:0]   done_in;
  logic                 mask_all;
  logic [NONCE_W:0]     lane_nonce;
  logic [NONCE_W:0]     next_sum;
  logic                 hit;

  assign accept     = (state_q == StLaunch) || (state_q == StWait);
  assign done_in    = accept ? lane_done_i : '0;
  assign mask_all   = &(mask_q | done_in);
  // All nonce arithmetic carries one extra bit so a batch past the top of the range never wraps.
  assign lane_nonce = {1'b0, batch_q} + NW1'(idx_q);
  assign next_sum   = {1'b0, batch_q} + NLanesW;
  assign hit        = (state_q == StScan) && (hash_buf_q[idx_q] < target_q) &&
                      (lane_nonce <= {1'b0, last_q});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(N_LANES); i++) begin
        hash_buf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_LANES); i++) begin
        if (done_in[i]) begin
          hash_buf_q[i] <= lane_hash_i[i*HASH_W +: HASH_W];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      cnt_q         <= '0;
      mask_q        <= '0;
      batch_q       <= '0;
      last_q        <= '0;
      target_q      <= '0;
      stop_q        <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      found_count_q <= '0;
      exhausted_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      batch_q       <= batch_d;
      last_q        <= last_d;
      target_q      <= target_d;
      stop_q        <= stop_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      found_count_q <= found_count_d;
      exhausted_q   <= exhausted_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    mask_d        = mask_q | done_in;
    batch_d       = batch_q;
    last_d        = last_q;
    target_d      = target_q;
    stop_d        = stop_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    found_count_d = found_count_q;
    exhausted_d   = exhausted_q;
    timeout_d     = timeout_q;
    lane_begin_o  = '0;
    done_o        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          last_d        = nonce_last_i;
          target_d      = target_i;
          stop_d        = stop_on_first_i;
          batch_d       = nonce_first_i;
          found_d       = 1'b0;
          found_nonce_d = '0;
          found_count_d = '0;
          exhausted_d   = 1'b0;
          timeout_d     = 1'b0;
          mask_d        = '0;
          idx_d         = '0;
          state_d       = StLaunch;
        end
      end
      StLaunch: begin
        if (STAGGER != 0) begin
          lane_begin_o = LaneZeroBit << idx_q;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = StWait;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          lane_begin_o = '1;
          cnt_d        = '0;
          state_d      = StWait;
        end
      end
      StWait: begin
        // A completing lane in this very cycle counts, so full-mask wins over timeout.
        if (mask_all) begin
          idx_d   = '0;
          state_d = StScan;
        end else if (cnt_q == TimeoutLast) begin
          timeout_d = 1'b1;
          state_d   = StFinish;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StScan: begin
        if (hit) begin
          if (found_count_q != 16'hFFFF) begin
            found_count_d = found_count_q + 16'd1;
          end
          if (!found_q) begin
            found_d       = 1'b1;
            found_nonce_d = lane_nonce[NONCE_W-1:0];
          end
        end
        if (hit && stop_q) begin
          state_d = StFinish;
        end else if (idx_q == LastIdx) begin
          state_d = StNext;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StNext: begin
        if (next_sum > {1'b0, last_q}) begin
          exhausted_d = 1'b1;
          state_d     = StFinish;
        end else begin
          batch_d = next_sum[NONCE_W-1:0];
          mask_d  = '0;
          idx_d   = '0;
          state_d = StLaunch;
        end
      end
      StFinish: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort freezes results where they stand and skips the completion pulse.
    if (abort_i && (state_q != StIdle)) begin
      state_d       = StIdle;
      lane_begin_o  = '0;
      done_o        = 1'b0;
      found_d       = found_q;
      found_nonce_d = found_nonce_q;
      found_count_d = found_count_q;
      exhausted_d   = exhausted_q;
      timeout_d     = timeout_q;
    end
  end

  assign batch_nonce_o = batch_q;
  assign busy_o        = (state_q != StIdle);
  assign found_o       = found_q;
  assign found_nonce_o = found_nonce_q;
  assign found_count_o = found_count_q;
  assign exhausted_o   = exhausted_q;
  assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_nonce_batch_scanner.sv
// Bench for nonce_batch_scanner: a staggered instance is driven by a lane model, and an
// all-at-once instance is driven by hand.
module tb_nonce_batch_scanner;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, stop_on_first = 1'b0;
  logic [15:0] target = '0;
  logic [31:0] nonce_first = '0, nonce_last = '0;
  logic [3:0]  lane_begin, lane_done;
  logic [63:0] lane_hash;
  logic [31:0] batch_nonce, found_nonce;
  logic        busy, done, found, exhausted, timeout_err;
  logic [15:0] found_count;

  logic        start0 = 1'b0, abort0 = 1'b0, stop0 = 1'b0;
  logic [15:0] target0 = '0;
  logic [31:0] nonce_first0 = '0, nonce_last0 = '0;
  logic [3:0]  lane_begin0, lane_done0 = '0;
  logic [63:0] lane_hash0 = '0;
  logic [31:0] batch_nonce0, found_nonce0;
  logic        busy0, done0, found0, exhausted0, timeout_err0;
  logic [15:0] found_count0;

  int n_cmp = 0, n_err = 0;
  int done_cnt = 0, beg_cnt = 0, beg_pos = 0;
  logic [15:0] hmem [16];
  logic [3:0]  mute = '0;
  int          cd [4];
  logic [31:0] ln [4];

  nonce_batch_scanner #(.N_LANES(4), .HASH_W(16), .NONCE_W(32), .STAGGER(1), .TIMEOUT(20)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .stop_on_first_i(stop_on_first),
    .target_i(target), .nonce_first_i(nonce_first), .nonce_last_i(nonce_last),
    .lane_begin_o(lane_begin), .lane_done_i(lane_done), .lane_hash_i(lane_hash),
    .batch_nonce_o(batch_nonce), .busy_o(busy), .done_o(done), .found_o(found),
    .found_nonce_o(found_nonce), .found_count_o(found_count), .exhausted_o(exhausted),
    .timeout_err_o(timeout_err));

  nonce_batch_scanner #(.N_LANES(4), .HASH_W(16), .NONCE_W(32), .STAGGER(0), .TIMEOUT(20)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .abort_i(abort0), .stop_on_first_i(stop0),
    .target_i(target0), .nonce_first_i(nonce_first0), .nonce_last_i(nonce_last0),
    .lane_begin_o(lane_begin0), .lane_done_i(lane_done0), .lane_hash_i(lane_hash0),
    .batch_nonce_o(batch_nonce0), .busy_o(busy0), .done_o(done0), .found_o(found0),
    .found_nonce_o(found_nonce0), .found_count_o(found_count0), .exhausted_o(exhausted0),
    .timeout_err_o(timeout_err0));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lane model: each begun lane returns hmem[nonce mod 16] LAT cycles after its begin pulse.
  always @(negedge clk) begin
    lane_done = '0;
    for (int i = 0; i < 4; i++) begin
      if (!busy) cd[i] = -1;
      else if (cd[i] == 0) begin
        lane_done[i] = !mute[i];
        lane_hash[i*16 +: 16] = hmem[ln[i][3:0]];
        cd[i] = -1;
      end else if (cd[i] > 0) cd[i] = cd[i] - 1;
      if (lane_begin[i]) begin
        cd[i] = LAT - 1;
        ln[i] = batch_nonce + 32'(i);
      end
    end
  end

  // Monitor: counts done pulses and checks the staggered begin walk.
  always @(negedge clk) begin
    logic [3:0] exp_lb;
    if (done) done_cnt++;
    if (!busy) beg_pos = 0;
    else if (lane_begin != 4'b0) begin
      exp_lb = 4'(1 << beg_pos);
      beg_cnt++;
      check("lane_begin_walk", 64'(lane_begin), 64'(exp_lb));
      beg_pos = (beg_pos + 1) % 4;
    end
  end

  task automatic run_sweep(input logic [31:0] f, input logic [31:0] l, input logic [15:0] tgt,
                           input logic stp);
    bit ok = 0;
    nonce_first = f; nonce_last = l; target = tgt; stop_on_first = stp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    if (!ok) check("done_seen", 0, 1);
    @(negedge clk);
  endtask

  task automatic sweep_and_check(input string pfx, input logic [31:0] f, input logic [31:0] l,
      input logic [15:0] tgt, input logic stp, input logic e_found, input logic [31:0] e_nonce,
      input logic [15:0] e_cnt, input logic e_exh, input logic [31:0] e_batch, input int e_beg);
    int d0 = done_cnt, b0 = beg_cnt;
    run_sweep(f, l, tgt, stp);
    check({pfx, "_found"}, 64'(found), 64'(e_found));
    if (e_found) check({pfx, "_found_nonce"}, 64'(found_nonce), 64'(e_nonce));
    check({pfx, "_found_count"}, 64'(found_count), 64'(e_cnt));
    check({pfx, "_exhausted"}, 64'(exhausted), 64'(e_exh));
    check({pfx, "_timeout_err"}, 64'(timeout_err), 0);
    check({pfx, "_batch_nonce"}, 64'(batch_nonce), 64'(e_batch));
    check({pfx, "_begins"}, 64'(beg_cnt - b0), 64'(e_beg));
    check({pfx, "_done_pulses"}, 64'(done_cnt - d0), 1);
    check({pfx, "_idle"}, 64'(busy), 0);
  endtask

  // Reference: walk the range nonce by nonce, counting hashes below target.
  task automatic model(input logic [31:0] f, input logic [31:0] l, input logic [15:0] tgt,
      input logic stp, output logic e_found, output logic [31:0] e_nonce, output logic [15:0] e_cnt,
      output logic e_exh, output logic [31:0] e_batch, output int e_beg);
    logic [32:0] n, fn;
    int batches;
    e_found = 0; fn = '0; e_cnt = 0; e_exh = 1;
    for (n = {1'b0, f}; n <= {1'b0, l}; n++) begin
      if (hmem[n[3:0]] < tgt) begin
        e_cnt++;
        if (!e_found) begin e_found = 1; fn = n; end
        if (stp) begin e_exh = 0; break; end
      end
    end
    e_nonce = fn[31:0];
    batches = (stp && e_found) ? int'((fn - {1'b0, f}) / 4) + 1 : int'(({1'b0, l} - {1'b0, f}) / 4) + 1;
    e_batch = f + 32'(4 * (batches - 1));
    e_beg = 4 * batches;
  endtask

  typedef struct {
    string       name;
    logic [31:0] first, last;
    logic [15:0] hits;
    logic        stop;
    logic        e_found;
    logic [31:0] e_nonce;
    logic [15:0] e_cnt;
    logic        e_exh;
    logic [31:0] e_batch;
    int          e_beg;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [15:0] hm;
    logic        ef, ee;
    logic [31:0] en, eb, f, l;
    logic [32:0] l33;
    logic [15:0] ec, tgt;
    logic        stp;
    int          eg, k;
    bit          seen;

    vecs[0] = '{"no_hits",     32'd0, 32'd7, 16'h0000, 1'b0, 1'b0, 32'd0, 16'd0, 1'b1, 32'd4, 8};
    vecs[1] = '{"stop_first",  32'd0, 32'd7, 16'h00C0, 1'b1, 1'b1, 32'd6, 16'd1, 1'b0, 32'd4, 8};
    vecs[2] = '{"full_sweep",  32'd0, 32'd7, 16'h0062, 1'b0, 1'b1, 32'd1, 16'd3, 1'b1, 32'd4, 8};
    vecs[3] = '{"top_of_range", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 16'hFFFF, 1'b0, 1'b1, 32'hFFFF_FFFE,
                16'd2, 1'b1, 32'hFFFF_FFFE, 4};
    vecs[4] = '{"single_nonce", 32'd3, 32'd3, 16'h0008, 1'b1, 1'b1, 32'd3, 16'd1, 1'b0, 32'd3, 4};
    vecs[5] = '{"tail_masked", 32'd5, 32'd13, 16'h6020, 1'b0, 1'b1, 32'd5, 16'd2, 1'b1, 32'd13, 12};

    for (int i = 0; i < 16; i++) hmem[i] = 16'hFFFF;
    lane_hash = '0;
    repeat (3) @(negedge clk);
    check("rst_lane_begin", 64'(lane_begin), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_found", 64'(found), 0);
    check("rst_found_count", 64'(found_count), 0);
    check("rst_found_nonce", 64'(found_nonce), 0);
    check("rst_exhausted", 64'(exhausted), 0);
    check("rst_timeout", 64'(timeout_err), 0);
    check("rst_batch", 64'(batch_nonce), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      hm = vecs[v].hits;
      for (int i = 0; i < 16; i++) hmem[i] = hm[i] ? 16'h00FF : 16'hFFFF;
      sweep_and_check(vecs[v].name, vecs[v].first, vecs[v].last, 16'h0100, vecs[v].stop,
                      vecs[v].e_found, vecs[v].e_nonce, vecs[v].e_cnt, vecs[v].e_exh,
                      vecs[v].e_batch, vecs[v].e_beg);
    end

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 16; i++) hmem[i] = 16'($urandom_range(0, 16'hFFFF));
      k = $urandom_range(1, 12);
      if ($urandom_range(0, 3) == 0) f = 32'hFFFF_FFFF - 32'($urandom_range(0, 13));
      else f = $urandom;
      l33 = {1'b0, f} + 33'(k - 1);
      if (l33 > 33'h0_FFFF_FFFF) l33 = 33'h0_FFFF_FFFF;
      l = l33[31:0];
      tgt = 16'($urandom_range(0, 16'hFFFF));
      stp = 1'($urandom_range(0, 1));
      model(f, l, tgt, stp, ef, en, ec, ee, eb, eg);
      sweep_and_check("rand", f, l, tgt, stp, ef, en, ec, ee, eb, eg);
    end

    // Lane 3 silent: timeout must land exactly TIMEOUT cycles into WAIT.
    for (int i = 0; i < 16; i++) hmem[i] = 16'hFFFF;
    mute = 4'b1000;
    nonce_first = 0; nonce_last = 7; target = 16'h0100; stop_on_first = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      if (lane_begin[3]) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) check("to_last_begin_seen", 0, 1);
    k = 0; seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      k++;
      if (timeout_err) begin seen = 1; break; end
    end
    check("to_latency", 64'(k), 21);
    check("to_done_with_err", 64'(done), 1);
    check("to_exhausted", 64'(exhausted), 0);
    @(negedge clk);
    check("to_idle", 64'(busy), 0);

    // Abort mid-WAIT: immediate idle, no done, sticky error cleared by the new start.
    k = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (lane_begin[3]) break;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("ab_busy_before", 64'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy_after", 64'(busy), 0);
    repeat (30) @(negedge clk);
    check("ab_no_done", 64'(done_cnt - k), 0);
    check("ab_timeout_clear", 64'(timeout_err), 0);
    mute = '0;

    // Abort during LAUNCH drops lane_begin combinationally.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (lane_begin == 4'b0010) break;
      @(negedge clk);
    end
    check("abl_begin_seen", 64'(lane_begin), 64'h2);
    abort = 1'b1;
    #1;
    check("abl_begin_forced", 64'(lane_begin), 0);
    @(negedge clk);
    abort = 1'b0;
    check("abl_idle", 64'(busy), 0);

    // Abort together with start in IDLE: start is ignored.
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abs_ignored", 64'(busy), 0);

    // Reset mid-sweep.
    nonce_first = 32'd8; nonce_last = 32'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (lane_begin == 4'b0100) break;
      @(negedge clk);
    end
    check("rs_batch_before", 64'(batch_nonce), 8);
    rst = 1'b1;
    #1;
    check("rs_begin_drop", 64'(lane_begin), 0);
    check("rs_busy", 64'(busy), 0);
    check("rs_batch", 64'(batch_nonce), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // All-at-once instance: every lane finishes during LAUNCH, start while busy is ignored.
    nonce_first0 = 0; nonce_last0 = 3; target0 = 16'h0100; stop0 = 0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("s0_begin_all", 64'(lane_begin0), 64'hF);
    lane_done0 = 4'hF;
    lane_hash0 = 64'hFFFF_FFFF_00FF_FFFF;
    @(negedge clk);
    lane_done0 = '0;
    lane_hash0 = '0;
    check("s0_begin_once", 64'(lane_begin0), 0);
    nonce_first0 = 32'd8; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done0) begin seen = 1; break; end
      @(negedge clk);
    end
    check("s0_done_seen", 64'(seen), 1);
    check("s0_timeout", 64'(timeout_err0), 0);
    check("s0_found", 64'(found0), 1);
    check("s0_found_nonce", 64'(found_nonce0), 1);
    check("s0_found_count", 64'(found_count0), 1);
    check("s0_exhausted", 64'(exhausted0), 1);
    check("s0_batch", 64'(batch_nonce0), 0);
    @(negedge clk);
    check("s0_idle", 64'(busy0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nonce_batch_scanner.md
Name: nonce_batch_scanner

Overview:
- Parametrised successor to the fixed ten-lane mining datapath. Sits between the CSR slave and N_LANES parallel SHA lanes.
- Sweeps a nonce range in batches of N_LANES:
  - launches the lanes (staggered or together);
  - collects each lane's hash on its done pulse;
  - scans the captured hashes one per cycle against the target;
  - reports first-hit nonce, hit count and exhaustion, timeout or abort status.
- Supports stop-on-first and full-sweep modes.

Parameters:
N_LANES, 10, number of parallel hash lanes (>=1); lane i in a batch hashes nonce batch_nonce+i
HASH_W, 256, hash and target width in bits
NONCE_W, 32, nonce width in bits
STAGGER, 1, 1 = lane_begin walks one lane per cycle; 0 = all lanes begun in the same cycle
TIMEOUT, 1024, max cycles in WAIT before timeout error (>=1)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a sweep; ignored while busy=1
abort  in  1  level; forces return to IDLE
stop_on_first  in  1  mode, sampled on start: 1 = finish at first hit, 0 = sweep whole range
target  in  HASH_W  unsigned target, sampled on start
nonce_first  in  NONCE_W  first nonce of range, sampled on start
nonce_last  in  NONCE_W  last nonce of range (inclusive), sampled on start; must be >= nonce_first
lane_begin  out  N_LANES  one-cycle begin pulse per lane
lane_done  in  N_LANES  one-cycle completion pulse per lane
lane_hash  in  N_LANES*HASH_W  lane i hash at bits [i*HASH_W +: HASH_W], valid while lane_done[i]=1
batch_nonce  out  NONCE_W  base nonce of current batch
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse on normal completion (hit, exhausted or timeout)
found  out  1  sticky: at least one hit since last start
found_nonce  out  NONCE_W  nonce of first hit
found_count  out  16  number of hits, saturates at 65535
exhausted  out  1  sticky: range fully scanned
timeout_err  out  1  sticky: WAIT exceeded TIMEOUT

Behaviour:
- Reset:
  - state IDLE;
  - all outputs 0;
  - capture buffer, done-mask and counters cleared.
- States: IDLE, LAUNCH, WAIT, SCAN, NEXT, FINISH.
- IDLE:
  - On start, sample the mode/target/range inputs, set batch_nonce=nonce_first and clear found, found_nonce, found_count, exhausted and timeout_err.
  - Go to LAUNCH next cycle.
- LAUNCH:
  - STAGGER=1: lane_begin[k] is high in exactly the k-th LAUNCH cycle (k=0..N_LANES-1), then WAIT.
  - STAGGER=0: all bits high for one cycle, then WAIT.
  - Lanes whose nonce exceeds nonce_last still get begun; their results are masked during SCAN.
- lane_done is accepted in LAUNCH and WAIT. Each pulse latches lane_hash[i] into buffer slot i and sets done-mask bit i. A repeated pulse overwrites the slot. Pulses in any other state are ignored.
- WAIT:
  - Cycle counter starts at 0 on entry.
  - When all mask bits are set, go to SCAN; this takes priority over timeout in the same cycle.
  - When the counter reaches TIMEOUT, set timeout_err and go to FINISH.
- SCAN:
  - Index i steps 0..N_LANES-1, one per cycle.
  - Hit = buffer[i] < target (strict, unsigned) AND batch_nonce+i <= nonce_last, computed in NONCE_W+1 bits.
  - On a hit: found_count += 1 (saturating). If found was 0, set found=1 and found_nonce = batch_nonce+i.
  - stop_on_first=1: a hit goes to FINISH in the next cycle; remaining lanes are not scanned.
  - After the last index, go to NEXT.
- NEXT:
  - Compute batch_nonce+N_LANES in NONCE_W+1 bits.
  - If it is > nonce_last or overflows NONCE_W: set exhausted and go to FINISH.
  - Otherwise batch_nonce += N_LANES, clear the done-mask, go to LAUNCH.
- FINISH: done=1 for one cycle, then IDLE. Result outputs hold until the next start.
- abort:
  - Any non-IDLE state goes to IDLE on the next edge.
  - lane_begin is forced 0 in that same cycle.
  - No done pulse; result outputs keep their current values.
  - abort in IDLE has no effect; abort and start together: abort wins, start is ignored.
- rst mid-sweep clears everything asynchronously; lane_begin drops immediately.
- Latency, N=4, STAGGER=1, lanes done 5 cycles after begin:
  - start@0;
  - lane_begin bits @1..4;
  - SCAN @10..13;
  - NEXT @14.
- Width rule: all nonce sums use NONCE_W+1 bits; batch_nonce never wraps.

Test Plan:
- N_LANES=4, HASH_W=16, STAGGER=1, nonce 0..7, target 0x0100, all hashes 0xFFFF -> two batches, lane_begin 0001,0010,0100,1000 per batch, exhausted=1, found=0, found_count=0, one done pulse.
- Same setup, lane 2 of batch 1 hashes 0x00FF, stop_on_first=1 -> found_nonce=6, found_count=1, batch 1 lane 3 not scanned, exhausted=0.
- stop_on_first=0, hits at nonces 1, 5, 6 in range 0..7 -> found_nonce=1, found_count=3, exhausted=1.
- Range 0xFFFFFFFE..0xFFFFFFFF, NONCE_W=32, N=4, hits on all lanes -> found_count=2 (lanes 2,3 masked), exhausted=1, batch_nonce stays 0xFFFFFFFE.
- Lane 3 never pulses lane_done, TIMEOUT=20 -> timeout_err=1 exactly 20 cycles after WAIT entry, then done pulse; abort in a second run mid-WAIT -> busy=0 next cycle, no done pulse.
- STAGGER=0 with all lane_done pulsing in one cycle during LAUNCH -> all four captured, SCAN entered without WAIT timeout; start while busy ignored.
